// File: rtl/count_monitor.sv
// Observer for a small up/down counter: classifies each sample-to-sample change,
// extends the count with a wrap accumulator and flags a debounced hold at cmp_val.
`timescale 1ns/1ps
module count_monitor #(
  parameter int CNT_W = 3,
  parameter int EXT_W = 5,
  parameter int HOLD  = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic [CNT_W-1:0]       cmp_val,
  output logic [EXT_W+CNT_W-1:0] ext_cnt,
  output logic                   wrap_up,
  output logic                   wrap_dn,
  output logic                   resync,
  output logic                   dir,
  output logic                   match
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [EXT_W-1:0] EXT_ONE = EXT_W'(1);
  localparam logic [3:0]       HOLD_C  = 4'(HOLD);

  typedef enum logic {T_INIT, T_TRACK} trk_t;
  typedef enum logic [1:0] {M_IDLE, M_ARM, M_HIT} mst_t;

  trk_t             trk_q, trk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXT_W-1:0] ext_hi_q, ext_hi_d;
  logic             dir_q, dir_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_dn_q, wrap_dn_d;
  logic             resync_q, resync_d;
  logic [CNT_W-1:0] cnt_inc, cnt_dec;

  mst_t             mst_q, mst_d;
  logic [3:0]       hc_q, hc_d;
  logic [3:0]       hc_inc;
  logic             eq;

  // Tracker state register
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      trk_q     <= T_INIT;
      cnt_q     <= '0;
      ext_hi_q  <= '0;
      dir_q     <= 1'b1;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      resync_q  <= 1'b0;
    end else begin
      trk_q     <= trk_d;
      cnt_q     <= cnt_d;
      ext_hi_q  <= ext_hi_d;
      dir_q     <= dir_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      resync_q  <= resync_d;
    end
  end

  assign cnt_inc = cnt_q + CNT_ONE;
  assign cnt_dec = cnt_q - CNT_ONE;

  always_comb begin
    trk_d     = trk_q;
    cnt_d     = cnt_in;
    ext_hi_d  = ext_hi_q;
    dir_d     = dir_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    resync_d  = 1'b0;
    case (trk_q)
      T_INIT: trk_d = T_TRACK;
      T_TRACK: begin
        if (cnt_in == cnt_q) begin
          dir_d = dir_q;
        end else if (cnt_in == cnt_inc) begin
          dir_d = 1'b1;
          if (cnt_q == CNT_MAX) begin
            ext_hi_d  = ext_hi_q + EXT_ONE;
            wrap_up_d = 1'b1;
          end
        end else if (cnt_in == cnt_dec) begin
          dir_d = 1'b0;
          if (cnt_q == '0) begin
            ext_hi_d  = ext_hi_q - EXT_ONE;
            wrap_dn_d = 1'b1;
          end
        end else begin
          // A load breaks the position history, so the accumulator restarts.
          ext_hi_d = '0;
          resync_d = 1'b1;
        end
      end
      default: trk_d = T_INIT;
    endcase
  end

  // Match state register
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      mst_q <= M_IDLE;
      hc_q  <= '0;
    end else begin
      mst_q <= mst_d;
      hc_q  <= hc_d;
    end
  end

  assign eq     = (cnt_in == cmp_val);
  assign hc_inc = hc_q + 4'd1;

  always_comb begin
    mst_d = mst_q;
    hc_d  = hc_q;
    case (mst_q)
      M_IDLE: begin
        if (eq) begin
          hc_d  = 4'd1;
          mst_d = (HOLD_C == 4'd1) ? M_HIT : M_ARM;
        end
      end
      M_ARM: begin
        if (eq) begin
          hc_d = hc_inc;
          if (hc_inc == HOLD_C) mst_d = M_HIT;
        end else begin
          hc_d  = '0;
          mst_d = M_IDLE;
        end
      end
      M_HIT: begin
        if (!eq) begin
          hc_d  = '0;
          mst_d = M_IDLE;
        end
      end
      default: begin
        hc_d  = '0;
        mst_d = M_IDLE;
      end
    endcase
  end

  assign ext_cnt = {ext_hi_q, cnt_q};
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;
  assign resync  = resync_q;
  assign dir     = dir_q;
  assign match   = (mst_q == M_HIT);

endmodule
